// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, active-video flag, pixel
// coordinates and line/frame event pulses derived from a divided system clock.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_tick,
    output logic          vga_HS,
    output logic          vga_VS,
    output logic          display,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [15:0]   frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);

    // Sync bounds carry one extra bit: the sync end may equal the total.
    localparam logic [CW:0] HS_BEGIN = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_BEGIN = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [CW-1:0] h;
    logic [CW-1:0] v;

    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_vis_nxt;
    logic          v_vis_nxt;
    logic          hs_on_nxt;
    logic          vs_on_nxt;
    logic          advance;

    assign advance = enable && (div == DIV_LAST);

    always_comb begin
        h_nxt = h + 1'b1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    always_comb begin
        h_vis_nxt = (h_nxt < H_ACT);
        v_vis_nxt = (v_nxt < V_ACT);
        hs_on_nxt = ({1'b0, h_nxt} >= HS_BEGIN) && ({1'b0, h_nxt} < HS_END);
        vs_on_nxt = ({1'b0, v_nxt} >= VS_BEGIN) && ({1'b0, v_nxt} < VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div          <= '0;
            h            <= H_LAST;
            v            <= V_LAST;
            pix_tick     <= 1'b0;
            vga_HS       <= ~HS_POL;
            vga_VS       <= ~VS_POL;
            display      <= 1'b0;
            X            <= '0;
            Y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            pix_tick     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (advance) begin
                div          <= '0;
                h            <= h_nxt;
                v            <= v_nxt;
                pix_tick     <= 1'b1;
                display      <= h_vis_nxt && v_vis_nxt;
                X            <= h_vis_nxt ? h_nxt : '0;
                Y            <= v_vis_nxt ? v_nxt : '0;
                vga_HS       <= hs_on_nxt ? HS_POL : ~HS_POL;
                vga_VS       <= vs_on_nxt ? VS_POL : ~VS_POL;
                line_start   <= (h_nxt == '0);
                frame_start  <= (h_nxt == '0) && (v_nxt == '0);
                vblank_start <= (h_nxt == '0) && (v_nxt == V_ACT);
                if ((h_nxt == '0) && (v_nxt == '0)) begin
                    frame_count <= frame_count + 16'd1;
                end
            end else if (enable) begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; expectations are derived from
// the count of enabled clocks since reset rather than from counter state.
module tb_vga_timing_gen;

    localparam int unsigned HA = 10, HFP = 2, HSW = 3, HBP = 4;
    localparam int unsigned VA = 6,  VFP = 1, VSW = 2, VBP = 2;
    localparam int unsigned DIV = 3;
    localparam int unsigned CWB = 6;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int unsigned HT = HA + HFP + HSW + HBP;
    localparam int unsigned VT = VA + VFP + VSW + VBP;
    localparam int unsigned FRAME = HT * VT;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           pix_tick, vga_HS, vga_VS, display;
    logic [CWB-1:0] X, Y;
    logic           line_start, frame_start, vblank_start;
    logic [15:0]    frame_count;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CLK_DIV(DIV), .CW(CWB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(pix_tick), .vga_HS(vga_HS), .vga_VS(vga_VS),
        .display(display), .X(X), .Y(Y),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference: n enabled clocks since reset; k = n/DIV pixels elapsed.
    int unsigned n = 0;
    bit          adv = 1'b0;
    int unsigned mh, mv;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_pos(output int unsigned h, output int unsigned v,
                             output int unsigned idx, output int unsigned fc);
        int unsigned k;
        k   = n / DIV;
        idx = (k + FRAME - 1) % FRAME;
        h   = idx % HT;
        v   = idx / HT;
        fc  = ((k + FRAME - 1) / FRAME) % 65536;
    endtask

    task automatic check_all();
        int unsigned h, v, idx, fc;
        bit hs_on, vs_on;
        model_pos(h, v, idx, fc);
        mh = h;
        mv = v;
        hs_on = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs_on = (v >= VA + VFP) && (v < VA + VFP + VSW);
        chk("pix_tick", pix_tick, adv);
        chk("display", display, (h < HA) && (v < VA));
        chk("X", X, (h < HA) ? h : 0);
        chk("Y", Y, (v < VA) ? v : 0);
        chk("vga_HS", vga_HS, hs_on ? HSP : !HSP);
        chk("vga_VS", vga_VS, vs_on ? VSP : !VSP);
        chk("line_start", line_start, adv && (h == 0));
        chk("frame_start", frame_start, adv && (idx == 0));
        chk("vblank_start", vblank_start, adv && (h == 0) && (v == VA));
        chk("frame_count", frame_count, fc);
    endtask

    task automatic step(input logic rst, input logic en);
        reset  = rst;
        enable = en;
        @(posedge clk);
        if (rst) begin
            n   = 0;
            adv = 1'b0;
        end else if (en) begin
            n++;
            adv = (n % DIV == 0);
        end else begin
            adv = 1'b0;
        end
        #1;
        check_all();
    endtask

    // Run enabled until the model reaches (th,tv) on an advance edge.
    task automatic run_to(input int unsigned th, input int unsigned tv, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME * DIV && !found; i++) begin
            step(1'b0, 1'b1);
            if (adv && mh == th && mv == tv) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    task automatic check_reset_values();
        chk("rst_display", display, 0);
        chk("rst_X", X, 0);
        chk("rst_Y", Y, 0);
        chk("rst_HS", vga_HS, !HSP);
        chk("rst_VS", vga_VS, !VSP);
        chk("rst_pulses", {pix_tick, line_start, frame_start, vblank_start}, 0);
        chk("rst_frame_count", frame_count, 0);
    endtask

    task automatic check_first_tick();
        for (int i = 1; i < DIV; i++) begin
            step(1'b0, 1'b1);
            chk("pre_tick", pix_tick, 0);
        end
        step(1'b0, 1'b1);
        chk("first_tick", pix_tick, 1);
        chk("first_X", X, 0);
        chk("first_Y", Y, 0);
        chk("first_display", display, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_line_start", line_start, 1);
        chk("first_frame_count", frame_count, 1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        check_reset_values();

        check_first_tick();

        // Two full frames enabled: sync windows, vblank, frame_count 1->3.
        for (int i = 0; i < 2 * FRAME * DIV; i++) step(1'b0, 1'b1);
        chk("frame_count_2frames", frame_count, 3);

        // Hold while at (5,3): everything frozen, then resume at (6,3).
        run_to(5, 3, "reach_5_3");
        for (int i = 0; i < 37; i++) begin
            step(1'b0, 1'b0);
            chk("hold_X", X, 5);
            chk("hold_Y", Y, 3);
        end
        begin
            bit ticked;
            ticked = 1'b0;
            for (int i = 0; i < DIV && !ticked; i++) begin
                step(1'b0, 1'b1);
                ticked = pix_tick;
            end
            chk("resume_tick", ticked, 1);
            chk("resume_X", X, 6);
            chk("resume_Y", Y, 3);
        end

        // Mid-frame reset overrides enable, then restart as from power-up.
        run_to(8, 4, "reach_8_4");
        step(1'b1, 1'b1);
        check_reset_values();
        check_first_tick();

        // Randomized enable with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7);
        end

        // Reset with a partially counted divider, then a held-enable check.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_reset_values();
        check_first_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
